hazard_ctrl: RTL

Pipeline hazard controller for the five-stage MIPS core. It keeps its own scoreboard of destination register and result-ready time for the instructions in E, M and W. From that scoreboard it drives stall/flush to PC, IF/ID and ID/EX, and the forwarding selects for D- and E-stage operands. It also owns the multiply/divide busy counter that holds md-class instructions in D.

---
 rtl/hazard_pkg.sv | 29 ++
 rtl/hazard_ctrl_if.sv | 31 +++
 rtl/md_busy_cnt.sv | 34 +++
 rtl/hazard_ctrl.sv | 96 +++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the five-stage pipeline hazard controller.
// Scoreboard entry layout, forwarding select codes, tuse and md-start encodings.
package hazard_pkg;

   typedef struct packed {
      logic [4:0] a3;
      logic       we;
      logic [1:0] tnew;
      logic [4:0] rs;
      logic [4:0] rt;
   } sb_entry_t;

   // D-operand selects: 0 RF, 1 E, 2 M.  E-operand selects: 0 pipe reg, 1 M, 2 W.
   localparam logic [1:0] FWD_RF = 2'd0;
   localparam logic [1:0] FWD_E  = 2'd1;
   localparam logic [1:0] FWD_M  = 2'd2;
   localparam logic [1:0] FWD_ME = 2'd1;
   localparam logic [1:0] FWD_W  = 2'd2;

   localparam logic [1:0] TUSE_NONE = 2'd3;

   localparam logic [1:0] MD_MULT = 2'b01;
   localparam logic [1:0] MD_DIV  = 2'b10;

   function automatic logic sb_match(input sb_entry_t e, input logic [4:0] r);
      return e.we && (e.a3 == r) && (r != 5'd0);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// D/E-stage hazard signals between the pipeline datapath and hazard_ctrl.
// master = datapath side, slave = hazard controller side.
interface hazard_ctrl_if;
   logic [4:0] rsD;
   logic [4:0] rtD;
   logic [1:0] tuse_rsD;
   logic [1:0] tuse_rtD;
   logic [4:0] a3D;
   logic       weD;
   logic [1:0] tnewD;
   logic       md_useD;
   logic [1:0] md_startE;
   logic       pc_en;
   logic       ifid_en;
   logic       idex_flush;
   logic [1:0] fwd_rsD;
   logic [1:0] fwd_rtD;
   logic [1:0] fwd_rsE;
   logic [1:0] fwd_rtE;
   logic       md_busy;

   modport master (
      output rsD, rtD, tuse_rsD, tuse_rtD, a3D, weD, tnewD, md_useD, md_startE,
      input  pc_en, ifid_en, idex_flush, fwd_rsD, fwd_rtD, fwd_rsE, fwd_rtE, md_busy
   );

   modport slave (
      input  rsD, rtD, tuse_rsD, tuse_rtD, a3D, weD, tnewD, md_useD, md_startE,
      output pc_en, ifid_en, idex_flush, fwd_rsD, fwd_rtD, fwd_rsE, fwd_rtE, md_busy
   );
endinterface

// File: rtl/md_busy_cnt.sv
// Multiply/divide busy counter: loads on an md start in E, counts down to zero.
// md_busy is high while the count is nonzero; a start while busy reloads.
module md_busy_cnt
   import hazard_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] md_start,
   output logic       md_busy
);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      case (md_start)
         MD_MULT: cnt_d = 4'(MULT_CYCLES);
         MD_DIV:  cnt_d = 4'(DIV_CYCLES);
         default: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign md_busy = (cnt_q != 4'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: E/M/W scoreboard drives stall/flush and D/E forwarding.
// Define HAZARD_MDU_EN to include the md busy counter and md-class stall.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic          clk,
   input logic          reset,
   hazard_ctrl_if.slave hz
);

   sb_entry_t e_q, e_d;
   sb_entry_t m_q, m_d;
   sb_entry_t w_q, w_d;
   logic      stall_rs, stall_rt, stall_md, stall;
   logic      md_busy;
   logic      sb_unused;

`ifdef HAZARD_MDU_EN
   md_busy_cnt #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md_busy_cnt (
      .clk      (clk),
      .reset    (reset),
      .md_start (hz.md_startE),
      .md_busy  (md_busy)
   );
   assign stall_md = hz.md_useD & (md_busy | (hz.md_startE != 2'b00));
`else
   logic md_inputs_unused;
   assign md_inputs_unused = ^{hz.md_useD, hz.md_startE};
   assign md_busy  = 1'b0;
   assign stall_md = 1'b0;
`endif

   // W only feeds E-operand forwarding; its tnew and everyone's rs/rt beyond E are dead.
   assign sb_unused = ^{m_q.rs, m_q.rt, w_q.tnew, w_q.rs, w_q.rt};

   always_comb begin
      stall_rs = (hz.tuse_rsD != TUSE_NONE) &&
                 ((sb_match(e_q, hz.rsD) && (e_q.tnew > hz.tuse_rsD)) ||
                  (sb_match(m_q, hz.rsD) && (m_q.tnew > hz.tuse_rsD)));
      stall_rt = (hz.tuse_rtD != TUSE_NONE) &&
                 ((sb_match(e_q, hz.rtD) && (e_q.tnew > hz.tuse_rtD)) ||
                  (sb_match(m_q, hz.rtD) && (m_q.tnew > hz.tuse_rtD)));
      stall    = stall_rs | stall_rt | stall_md;
   end

   always_comb begin
      hz.fwd_rsD = FWD_RF;
      if (sb_match(e_q, hz.rsD) && (e_q.tnew == 2'd0))      hz.fwd_rsD = FWD_E;
      else if (sb_match(m_q, hz.rsD) && (m_q.tnew == 2'd0)) hz.fwd_rsD = FWD_M;

      hz.fwd_rtD = FWD_RF;
      if (sb_match(e_q, hz.rtD) && (e_q.tnew == 2'd0))      hz.fwd_rtD = FWD_E;
      else if (sb_match(m_q, hz.rtD) && (m_q.tnew == 2'd0)) hz.fwd_rtD = FWD_M;

      hz.fwd_rsE = FWD_RF;
      if (sb_match(m_q, e_q.rs) && (m_q.tnew == 2'd0)) hz.fwd_rsE = FWD_ME;
      else if (sb_match(w_q, e_q.rs))                  hz.fwd_rsE = FWD_W;

      hz.fwd_rtE = FWD_RF;
      if (sb_match(m_q, e_q.rt) && (m_q.tnew == 2'd0)) hz.fwd_rtE = FWD_ME;
      else if (sb_match(w_q, e_q.rt))                  hz.fwd_rtE = FWD_W;
   end

   always_comb begin
      e_d = '0;
      if (!stall) e_d = '{a3: hz.a3D, we: hz.weD, tnew: hz.tnewD, rs: hz.rsD, rt: hz.rtD};
      m_d      = e_q;
      m_d.tnew = (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
      w_d      = m_q;
      w_d.tnew = 2'd0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e_q <= '0;
         m_q <= '0;
         w_q <= '0;
      end else begin
         e_q <= e_d;
         m_q <= m_d;
         w_q <= w_d;
      end
   end

   assign hz.pc_en      = ~stall;
   assign hz.ifid_en    = ~stall;
   assign hz.idex_flush = stall;
   assign hz.md_busy    = md_busy;

endmodule
